// File: rtl/pio_mem_pipe.sv
// Byte-writable word memory with a power-up/reset clear sweep, a fixed-latency
// read pipeline and a credit-protected response FIFO with valid/ready handshake.
module pio_mem_pipe #(
    parameter int DATA_WIDTH      = 512,
    parameter int DEPTH           = 128,
    parameter int BYTE_ADDR_WIDTH = 13,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [BYTE_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_rsp_valid,
    input  logic                       rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]      rd_rsp_data,
    input  logic                       wr_en,
    input  logic [BYTE_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH/8-1:0]    wr_be,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       init_busy
);

    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(BE_W);
    localparam int WA_W       = $clog2(DEPTH);
    localparam int FIFO_DEPTH = READ_LATENCY + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W      = $clog2(READ_LATENCY + 1);
    localparam int SUM_W      = CNT_W + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WA_W-1:0]         sweep_q, sweep_d;
    logic [WA_W-1:0]         rd_word_s, wr_word_s;
    logic                    unused_addr_bits_s;

    logic                    mem_we_s;
    logic [WA_W-1:0]         mem_waddr_s;
    logic [BE_W-1:0]         mem_wbe_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept_s;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_data_d [READ_LATENCY];
    logic [LAT_W-1:0]        inflight_d;

    logic                    push_s, pop_s;
    logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d, fifo_rem_s;

    logic                    rd_req_ready_q, rd_req_ready_d;
    logic                    rd_rsp_valid_q, rd_rsp_valid_d;
    logic                    init_busy_q, init_busy_d;
    logic [DATA_WIDTH-1:0]   rd_rsp_data_q, rd_rsp_data_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    function automatic logic [LAT_W-1:0] count_valid(input logic [READ_LATENCY-1:0] v);
        logic [LAT_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            n = n + LAT_W'(v[i]);
        end
        return n;
    endfunction

    // Byte offset bits are dropped; upper bits beyond the array wrap naturally.
    assign rd_word_s          = rd_addr[BYTE_ADDR_WIDTH-1:OFF_W];
    assign wr_word_s          = wr_addr[BYTE_ADDR_WIDTH-1:OFF_W];
    assign unused_addr_bits_s = ^{rd_addr[OFF_W-1:0], wr_addr[OFF_W-1:0]};

    // Control FSM: clear sweep over every word, then normal operation.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + WA_W'(1);
                if (sweep_q == WA_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Array write port: the sweep owns the port in INIT, user writes in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wbe_s   = '0;
        mem_wdata_s = '0;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = sweep_q;
            mem_wbe_s   = '1;
            mem_wdata_s = '0;
        end else if (wr_en) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_word_s;
            mem_wbe_s   = wr_be;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Byte-masked array storage.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_wbe_s[b]) begin
                    mem_q[mem_waddr_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 samples the array before this edge's write lands.
    always_comb begin
        accept_s       = rd_req_valid & rd_req_ready_q;
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = accept_s;
        pipe_data_d[0] = mem_q[rd_word_s];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
        inflight_d = count_valid(pipe_vld_d);
    end

    // Response FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        push_s     = pipe_vld_q[READ_LATENCY-1];
        pop_s      = rd_rsp_valid_q & rd_rsp_ready;
        wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_rem_s = fifo_cnt_q - CNT_W'(pop_s);
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        init_busy_d    = (state_d == ST_INIT);
        rd_rsp_valid_d = (fifo_cnt_d != CNT_W'(0));
        // Credits count the post-edge state, so a pop frees a slot one cycle later.
        rd_req_ready_d = (state_d == ST_RUN) &&
                         ((SUM_W'(fifo_cnt_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH));

        if (fifo_cnt_d == CNT_W'(0)) begin
            rd_rsp_data_d = '0;
        end else if (fifo_rem_s == CNT_W'(0)) begin
            rd_rsp_data_d = pipe_data_q[READ_LATENCY-1];
        end else begin
            rd_rsp_data_d = fifo_q[rd_ptr_d];
        end
    end

    // Control, valid and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            sweep_q        <= '0;
            pipe_vld_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            rd_req_ready_q <= 1'b0;
            rd_rsp_valid_q <= 1'b0;
            init_busy_q    <= 1'b1;
            rd_rsp_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            pipe_vld_q     <= pipe_vld_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            rd_req_ready_q <= rd_req_ready_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            init_busy_q    <= init_busy_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
        end
    end

    // Data-only storage for pipeline stages and FIFO slots; qualified by valids.
    always_ff @(posedge clk) begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
        end
        if (push_s) begin
            fifo_q[wr_ptr_q] <= pipe_data_q[READ_LATENCY-1];
        end
    end

    assign rd_req_ready = rd_req_ready_q;
    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_data  = rd_rsp_data_q;
    assign init_busy    = init_busy_q;

endmodule

// File: tb/tb_pio_mem_pipe.sv
// Directed bench: a default-size instance (latency 1) and a small latency-3
// instance for back-pressure and mid-flight reset behaviour.
module tb_pio_mem_pipe;

    localparam int DW    = 512;
    localparam int DEPTH = 128;
    localparam int BAW   = 13;
    localparam int RL    = 1;

    localparam int B_DW    = 64;
    localparam int B_DEPTH = 16;
    localparam int B_BAW   = 7;
    localparam int B_RL    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
    logic [BAW-1:0]    rd_addr, wr_addr;
    logic [DW-1:0]     rd_rsp_data, wr_data;
    logic              wr_en, init_busy;
    logic [DW/8-1:0]   wr_be;

    logic              b_rst, b_rd_req_valid, b_rd_req_ready, b_rd_rsp_valid, b_rd_rsp_ready;
    logic [B_BAW-1:0]  b_rd_addr, b_wr_addr;
    logic [B_DW-1:0]   b_rd_rsp_data, b_wr_data;
    logic              b_wr_en, b_init_busy;
    logic [B_DW/8-1:0] b_wr_be;

    pio_mem_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_ADDR_WIDTH(BAW), .READ_LATENCY(RL)) u_dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .init_busy(init_busy)
    );

    pio_mem_pipe #(.DATA_WIDTH(B_DW), .DEPTH(B_DEPTH), .BYTE_ADDR_WIDTH(B_BAW), .READ_LATENCY(B_RL)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .rd_req_valid(b_rd_req_valid), .rd_req_ready(b_rd_req_ready), .rd_addr(b_rd_addr),
        .rd_rsp_valid(b_rd_rsp_valid), .rd_rsp_ready(b_rd_rsp_ready), .rd_rsp_data(b_rd_rsp_data),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
        .init_busy(b_init_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input logic [BAW-1:0] addr, input logic [DW/8-1:0] be, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_be = be; wr_data = data;
        tick();
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic a_rd(input string tag, input logic [BAW-1:0] addr, input logic [DW-1:0] exp);
        int n;
        int lat;
        rd_req_valid = 1'b1; rd_addr = addr; n = 0;
        while (!rd_req_ready && n < 64) begin tick(); n++; end
        tick();
        rd_req_valid = 1'b0; lat = 1;
        while (!rd_rsp_valid && lat < 64) begin tick(); lat++; end
        chk({tag, "_lat"}, 512'(lat), 512'(RL + 1));
        chk({tag, "_data"}, rd_rsp_data, exp);
        tick();
    endtask

    task automatic a_collect(input string tag, input logic [DW-1:0] exp);
        int n;
        n = 0;
        while (!rd_rsp_valid && n < 64) begin tick(); n++; end
        chk(tag, rd_rsp_data, exp);
        tick();
    endtask

    task automatic b_wr(input logic [B_BAW-1:0] addr, input logic [B_DW-1:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_be = '1; b_wr_data = data;
        tick();
        b_wr_en = 1'b0; b_wr_be = '0;
    endtask

    task automatic b_rd(input string tag, input logic [B_BAW-1:0] addr, input logic [B_DW-1:0] exp);
        int n;
        int lat;
        b_rd_req_valid = 1'b1; b_rd_addr = addr; n = 0;
        while (!b_rd_req_ready && n < 64) begin tick(); n++; end
        tick();
        b_rd_req_valid = 1'b0; lat = 1;
        while (!b_rd_rsp_valid && lat < 64) begin tick(); lat++; end
        chk({tag, "_lat"}, 512'(lat), 512'(B_RL + 1));
        chk({tag, "_data"}, 512'(b_rd_rsp_data), 512'(exp));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0]   pat;
        logic [13:0]     wrap_addr;
        logic [B_DW-1:0] b_val [4];
        logic [B_DW-1:0] held;
        int n;
        int seen;
        int acc;

        rst = 1'b1; rd_req_valid = 1'b0; rd_addr = '0; rd_rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        b_rst = 1'b1; b_rd_req_valid = 1'b0; b_rd_addr = '0; b_rd_rsp_ready = 1'b1;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_be = '0; b_wr_data = '0;
        repeat (3) tick();

        chk("rst_ready", 512'(rd_req_ready), 512'(1'b0));
        chk("rst_valid", 512'(rd_rsp_valid), 512'(1'b0));
        chk("rst_busy",  512'(init_busy),    512'(1'b1));
        chk("rst_data",  rd_rsp_data,        512'(1'b0));

        // Sweep with a write held on word 0 that must be ignored.
        rst = 1'b0;
        n = 0; seen = 0;
        wr_en = 1'b1; wr_addr = '0; wr_be = '1; wr_data = '1;
        while (init_busy && n < 1000) begin
            if (rd_req_ready) seen++;
            tick(); n++;
        end
        wr_en = 1'b0; wr_be = '0;
        chk("init_cycles",     512'(n),            512'(DEPTH));
        chk("init_ready_low",  512'(seen),         512'(0));
        chk("run_ready",       512'(rd_req_ready), 512'(1'b1));

        a_rd("w0_init_wr_ignored", 13'h0000, '0);
        a_rd("w5_zero",            13'h0140, '0);

        a_wr(13'h00C0, 64'h0000_0000_0000_00FF, '1);
        a_rd("w3_be", 13'h00C0, {448'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        a_wr(13'h00C0, 64'h0, '0);
        a_rd("w3_be0_noop", 13'h00C0, {448'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        a_wr(13'h00C0, 64'h0000_0000_0000_0100, {64{8'hAA}});
        a_rd("w3_byte8", 13'h00C0, {440'd0, 8'hAA, 64'hFFFF_FFFF_FFFF_FFFF});

        // Read-first: same-cycle write hidden, next-cycle read sees it.
        a_wr(13'h01C0, '1, {64{8'h55}});
        wr_en = 1'b1; wr_addr = 13'h01C0; wr_be = '1; wr_data = {64{8'hAA}};
        rd_req_valid = 1'b1; rd_addr = 13'h01C0;
        tick();
        wr_en = 1'b0; wr_be = '0;
        tick();
        rd_req_valid = 1'b0;
        a_collect("w7_same_cycle", {64{8'h55}});
        a_collect("w7_next_cycle", {64{8'hAA}});

        wrap_addr = 14'h2040;
        pat = {16{32'hDEAD_BEEF}};
        a_wr(wrap_addr[12:0], '1, pat);
        a_rd("wrap_w1", 13'h0047, pat);

        // Small latency-3 instance.
        chk("b_rst_ready", 512'(b_rd_req_ready), 512'(1'b0));
        chk("b_rst_busy",  512'(b_init_busy),    512'(1'b1));
        b_rst = 1'b0;
        n = 0;
        while (b_init_busy && n < 1000) begin tick(); n++; end
        chk("b_init_cycles", 512'(n), 512'(B_DEPTH));

        for (int k = 0; k < 4; k++) begin
            b_val[k] = 64'h0123_4567_89AB_CDE0 + 64'(k);
            b_wr(7'(k * 8), b_val[k]);
        end
        b_rd("b_w2", 7'h10, b_val[2]);

        b_rd_rsp_ready = 1'b0;
        b_rd_req_valid = 1'b1; b_rd_addr = 7'h00; acc = 0;
        for (int c = 0; c < 16; c++) begin
            if (b_rd_req_ready) begin
                acc++;
                tick();
                b_rd_addr = 7'(acc * 8);
            end else begin
                tick();
            end
        end
        b_rd_req_valid = 1'b0;
        chk("b_accepted",     512'(acc),            512'(4));
        chk("b_ready_full",   512'(b_rd_req_ready), 512'(1'b0));
        chk("b_stall_valid",  512'(b_rd_rsp_valid), 512'(1'b1));
        held = b_rd_rsp_data;
        repeat (3) tick();
        chk("b_stall_stable", 512'(b_rd_rsp_data), 512'(held));
        b_rd_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!b_rd_rsp_valid && n < 64) begin tick(); n++; end
            chk($sformatf("b_order%0d", k), 512'(b_rd_rsp_data), 512'(b_val[k]));
            tick();
        end

        // Reset with two reads still in the pipeline.
        b_rd_req_valid = 1'b1; b_rd_addr = 7'h08; n = 0;
        while (!b_rd_req_ready && n < 64) begin tick(); n++; end
        tick();
        tick();
        b_rd_req_valid = 1'b0;
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        n = 0; seen = 0;
        while (b_init_busy && n < 1000) begin
            if (b_rd_rsp_valid) seen++;
            tick(); n++;
        end
        repeat (10) begin
            if (b_rd_rsp_valid) seen++;
            tick();
        end
        chk("b_reinit_cycles", 512'(n),    512'(B_DEPTH));
        chk("b_flushed_rsp",   512'(seen), 512'(0));
        b_rd("b_w1_cleared", 7'h08, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
